// File: rtl/intan_emu_pkg.sv
// Shared types, constants and decode helpers for the Intan peripheral emulator.
package intan_emu_pkg;

   localparam int unsigned WORD_W       = 16;
   localparam int unsigned REG_W        = 8;
   localparam int unsigned ADDR_W       = 6;
   localparam int unsigned NUM_REGS     = 18;
   localparam int unsigned REG_IDX_W    = 5;
   localparam int unsigned WRITABLE_MAX = 17;
   localparam int unsigned RISE_CNT_W   = 5;
   localparam int unsigned BITS_PER_WORD = 16;

   localparam logic [WORD_W-1:0] CALIBRATE_CMD = 16'h5500;
   localparam logic [WORD_W-1:0] CLEAR_CMD     = 16'h6A00;

   // Read-only identity registers: 40..44 spell "INTAN", 60..63 are chip info.
   localparam logic [4:0][REG_W-1:0] ID_ROM   = {8'h4E, 8'h41, 8'h54, 8'h4E, 8'h49};
   localparam logic [3:0][REG_W-1:0] CHIP_ROM = {8'h01, 8'h20, 8'h00, 8'h01};

   typedef enum logic [1:0] {
      OP_CONVERT = 2'b00,
      OP_SPECIAL = 2'b01,
      OP_WRITE   = 2'b10,
      OP_READ    = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [WORD_W-1:0] a0;
      logic [WORD_W-1:0] b0;
      logic [WORD_W-1:0] a1;
      logic [WORD_W-1:0] b1;
   } response_t;

   function automatic logic [REG_W-1:0] rom_value(input logic [ADDR_W-1:0] addr);
      logic [REG_W-1:0] v;
      v = '0;
      if (addr >= 6'd40 && addr <= 6'd44) v = ID_ROM[3'(addr - 6'd40)];
      else if (addr >= 6'd60)             v = CHIP_ROM[2'(addr - 6'd60)];
      return v;
   endfunction

   function automatic logic [WORD_W-1:0] convert_word(input logic line, input logic sub,
                                                      input logic [ADDR_W-1:0] ch,
                                                      input logic [REG_W-1:0] fc8);
      return {line, sub, ch, fc8};
   endfunction

   function automatic response_t same_words(input logic [WORD_W-1:0] w);
      response_t r;
      r.a0 = w;
      r.b0 = w;
      r.a1 = w;
      r.b1 = w;
      return r;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall pulses
// derived from the synchronized copy.
module sync_edge_detect #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_sr;
   logic              q_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_sr <= {STAGES{RST_VAL}};
         q_prev  <= RST_VAL;
      end else begin
         sync_sr <= {sync_sr[STAGES-2:0], d};
         q_prev  <= sync_sr[STAGES-1];
      end
   end

   assign q      = sync_sr[STAGES-1];
   assign rise_c = q & ~q_prev;
   assign fall_c = ~q & q_prev;

endmodule

// File: rtl/intan_peripheral_emulator.sv
// SPI peripheral model of a dual-line Intan amplifier: decodes 16-bit commands
// and returns pipelined A/B response words on cipo0/cipo1.
module intan_peripheral_emulator
   import intan_emu_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PIPE_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        csn,
   input  logic        sclk,
   input  logic        copi,
   output logic        cipo0,
   output logic        cipo1,
   output logic [31:0] frame_count,
   output logic [15:0] bad_frame_count,
   output logic [15:0] last_command
);

   localparam int unsigned PIPE_LAST = PIPE_DEPTH - 1;

   logic csn_q, csn_rise_c, csn_fall_c;
   logic sclk_q, sclk_rise_c, sclk_fall_c;
   logic copi_q, copi_rise_c, copi_fall_c;
   logic unused_c;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
      .clk(clk), .rst(rst), .d(csn), .q(csn_q), .rise_c(csn_rise_c), .fall_c(csn_fall_c));
   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c));
   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .d(copi), .q(copi_q), .rise_c(copi_rise_c), .fall_c(copi_fall_c));

   assign unused_c = ^{csn_q, sclk_q, copi_rise_c, copi_fall_c};

   state_e                  state, state_next;
   logic                    do_load_c, do_rise_c, do_fall_c, do_commit_c, do_bad_c;
   response_t               pipe [PIPE_DEPTH];
   response_t               frame_resp;
   response_t               resp_c;
   logic [WORD_W-1:0]       cmd_sr;
   logic [RISE_CNT_W-1:0]   rise_cnt;
   logic [REG_W-1:0]        regs [NUM_REGS];
   logic [REG_W-1:0]        read_val_c;
   logic [3:0]              bit_idx_c;
   logic                    in_window_c;
   opcode_e                 cmd_op_c;
   logic [ADDR_W-1:0]       cmd_addr_c;
   logic [REG_W-1:0]        cmd_data_c;
   logic                    cmd_writable_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      do_load_c   = 1'b0;
      do_rise_c   = 1'b0;
      do_fall_c   = 1'b0;
      do_commit_c = 1'b0;
      do_bad_c    = 1'b0;
      if (!enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (csn_fall_c) begin
                  state_next = ST_SHIFT;
                  do_load_c  = 1'b1;
               end
            end
            ST_SHIFT: begin
               if (csn_rise_c) begin
                  state_next = ST_DONE;
               end else begin
                  do_rise_c = sclk_rise_c;
                  do_fall_c = sclk_fall_c;
               end
            end
            ST_DONE: begin
               state_next = ST_IDLE;
               if (rise_cnt == RISE_CNT_W'(BITS_PER_WORD)) do_commit_c = 1'b1;
               else                                        do_bad_c    = 1'b1;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Bit position follows the rise count: rise k sends B[15-k], the fall after it A[14-k].
   assign in_window_c = rise_cnt < RISE_CNT_W'(BITS_PER_WORD);
   assign bit_idx_c   = ~rise_cnt[3:0];

   assign cmd_op_c       = opcode_e'(cmd_sr[15:14]);
   assign cmd_addr_c     = cmd_sr[13:8];
   assign cmd_data_c     = cmd_sr[7:0];
   assign cmd_writable_c = cmd_addr_c <= ADDR_W'(WRITABLE_MAX);

   always_comb begin
      read_val_c = rom_value(cmd_addr_c);
      if (cmd_writable_c) read_val_c = regs[REG_IDX_W'(cmd_addr_c)];
   end

   always_comb begin
      resp_c = '0;
      case (cmd_op_c)
         OP_CONVERT: begin
            resp_c.a0 = convert_word(1'b0, 1'b0, cmd_addr_c, frame_count[7:0]);
            resp_c.b0 = convert_word(1'b0, 1'b1, cmd_addr_c, frame_count[7:0]);
            resp_c.a1 = convert_word(1'b1, 1'b0, cmd_addr_c, frame_count[7:0]);
            resp_c.b1 = convert_word(1'b1, 1'b1, cmd_addr_c, frame_count[7:0]);
         end
         OP_SPECIAL: resp_c = same_words(16'h0000);
         OP_WRITE:   resp_c = same_words({8'hFF, cmd_data_c});
         OP_READ:    resp_c = same_words({8'h00, read_val_c});
         default:    resp_c = '0;
      endcase
   end

   // Serial datapath, response pipeline and register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cipo0           <= 1'b0;
         cipo1           <= 1'b0;
         frame_count     <= '0;
         bad_frame_count <= '0;
         last_command    <= '0;
         cmd_sr          <= '0;
         rise_cnt        <= '0;
         frame_resp      <= '0;
         for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe[i] <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++)   regs[i] <= '0;
      end else begin
         if (!enable || state == ST_DONE) begin
            cipo0 <= 1'b0;
            cipo1 <= 1'b0;
         end else if (do_load_c) begin
            cipo0 <= pipe[0].a0[15];
            cipo1 <= pipe[0].a1[15];
         end else if (do_rise_c) begin
            cipo0 <= in_window_c & frame_resp.b0[bit_idx_c];
            cipo1 <= in_window_c & frame_resp.b1[bit_idx_c];
         end else if (do_fall_c) begin
            cipo0 <= in_window_c & frame_resp.a0[bit_idx_c];
            cipo1 <= in_window_c & frame_resp.a1[bit_idx_c];
         end

         if (do_load_c) begin
            frame_resp <= pipe[0];
            rise_cnt   <= '0;
         end

         if (do_rise_c) begin
            if (in_window_c) cmd_sr <= {cmd_sr[14:0], copi_q};
            if (rise_cnt <= RISE_CNT_W'(BITS_PER_WORD)) rise_cnt <= rise_cnt + 1'b1;
         end

         if (do_commit_c) begin
            for (int i = 0; i < int'(PIPE_DEPTH) - 1; i++) pipe[i] <= pipe[i+1];
            pipe[PIPE_LAST] <= resp_c;
            frame_count     <= frame_count + 1'b1;
            last_command    <= cmd_sr;
            if (cmd_op_c == OP_WRITE && cmd_writable_c)
               regs[REG_IDX_W'(cmd_addr_c)] <= cmd_data_c;
         end

         if (do_bad_c && bad_frame_count != 16'hFFFF)
            bad_frame_count <= bad_frame_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_intan_peripheral_emulator.sv
// Directed plus randomized frames against a command-level model of the emulator.
module tb_intan_peripheral_emulator;

   localparam int PIPE_DEPTH = 2;
   localparam int HALF       = 80;

   logic        clk = 1'b0;
   logic        rst, enable, csn, sclk, copi;
   logic        cipo0, cipo1;
   logic [31:0] frame_count;
   logic [15:0] bad_frame_count, last_command;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   logic [7:0]  m_regs [64];
   logic [63:0] m_q [$];
   logic [31:0] m_fc;
   logic [15:0] m_bfc;
   logic [15:0] m_last;

   intan_peripheral_emulator #(.SYNC_STAGES(2), .PIPE_DEPTH(PIPE_DEPTH)) dut (
      .clk(clk), .rst(rst), .enable(enable), .csn(csn), .sclk(sclk), .copi(copi),
      .cipo0(cipo0), .cipo1(cipo1), .frame_count(frame_count),
      .bad_frame_count(bad_frame_count), .last_command(last_command));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input int addr);
      if (addr <= 17) return m_regs[addr];
      case (addr)
         40: return 8'h49;
         41: return 8'h4E;
         42: return 8'h54;
         43: return 8'h41;
         44: return 8'h4E;
         60: return 8'h01;
         62: return 8'h20;
         63: return 8'h01;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
      m_q.delete();
      for (int i = 0; i < PIPE_DEPTH; i++) m_q.push_back(64'h0);
      m_fc = 0; m_bfc = 0; m_last = 0;
   endtask

   task automatic model_commit(input logic [15:0] cmd);
      int op, addr, data, fc8;
      logic [15:0] w;
      logic [63:0] r;
      op = int'(cmd) / 16384;
      addr = (int'(cmd) / 256) % 64;
      data = int'(cmd) % 256;
      fc8 = int'(m_fc % 256);
      r = 64'h0;
      case (op)
         0: r = {16'(addr * 256 + fc8), 16'(16384 + addr * 256 + fc8),
                 16'(32768 + addr * 256 + fc8), 16'(49152 + addr * 256 + fc8)};
         1: r = 64'h0;
         2: begin
            if (addr <= 17) m_regs[addr] = 8'(data);
            w = 16'(65280 + data);
            r = {w, w, w, w};
         end
         default: begin
            w = 16'(m_read(addr));
            r = {w, w, w, w};
         end
      endcase
      m_q.push_back(r);
      void'(m_q.pop_front());
      m_fc = m_fc + 1;
      m_last = cmd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #20;
      rst = 1'b0;
      model_reset();
      #20;
   endtask

   // One SPI frame; drop_at >= 0 deasserts enable before that rise.
   task automatic frame(input string tag, input logic [15:0] cmd, input int rises,
                        input int drop_at, output logic [63:0] got);
      logic [15:0] a0, b0, a1, b1;
      logic [63:0] exp;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      exp = m_q[0];
      csn = 1'b0;
      copi = cmd[15];
      #(HALF);
      for (int i = 0; i < rises; i++) begin
         if (i == drop_at) enable = 1'b0;
         if (i < 16) begin a0[15-i] = cipo0; a1[15-i] = cipo1; end
         sclk = 1'b1;
         #(HALF);
         if (i < 16) begin b0[15-i] = cipo0; b1[15-i] = cipo1; end
         if (i == drop_at) check({tag, "_abort_cipo"}, {62'h0, cipo1, cipo0}, 64'h0);
         sclk = 1'b0;
         copi = (i < 15) ? cmd[14-i] : 1'b0;
         #(HALF);
      end
      got = {a0, b0, a1, b1};
      if (drop_at < 0 && rises >= 16) begin
         check({tag, "_a0"}, 64'(a0), 64'(exp[63:48]));
         check({tag, "_b0"}, 64'(b0), 64'(exp[47:32]));
         check({tag, "_a1"}, 64'(a1), 64'(exp[31:16]));
         check({tag, "_b1"}, 64'(b1), 64'(exp[15:0]));
      end
      if (drop_at < 0 && rises == 16)
         check({tag, "_tail_zero"}, {62'h0, cipo1, cipo0}, 64'h0);
      csn = 1'b1;
      #(2*HALF);
      if (drop_at >= 0) begin
         enable = 1'b1;
         #(2*HALF);
      end else if (rises == 16) begin
         model_commit(cmd);
      end else if (m_bfc != 16'hFFFF) begin
         m_bfc = m_bfc + 1;
      end
      check({tag, "_fc"},   64'(frame_count),     64'(m_fc));
      check({tag, "_bfc"},  64'(bad_frame_count), 64'(m_bfc));
      check({tag, "_last"}, 64'(last_command),    64'(m_last));
   endtask

   initial begin
      logic [63:0] got;
      logic [15:0] cmd;
      int rises;
      rst = 1'b1; enable = 1'b1; csn = 1'b1; sclk = 1'b0; copi = 1'b0;
      model_reset();
      #23;
      rst = 1'b0;
      #20;
      check("reset_cipo", {62'h0, cipo1, cipo0}, 64'h0);
      check("reset_fc",   64'(frame_count), 64'h0);
      check("reset_bfc",  64'(bad_frame_count), 64'h0);
      check("reset_last", 64'(last_command), 64'h0);

      // READ 40 three times: zeros, zeros, then 'I'
      frame("rd40_1", 16'hE800, 16, -1, got);
      check("rd40_1_const", got, 64'h0);
      frame("rd40_2", 16'hE800, 16, -1, got);
      frame("rd40_3", 16'hE800, 16, -1, got);
      check("rd40_3_const", got, {4{16'h0049}});
      check("rd40_fc3", 64'(frame_count), 64'd3);

      // WRITE then READ reg 5
      do_reset();
      frame("wr5", 16'h85A7, 16, -1, got);
      frame("rd5", 16'hC500, 16, -1, got);
      frame("cv_d1", 16'h0100, 16, -1, got);
      check("wr5_resp", got, {4{16'hFFA7}});
      frame("cv_d2", 16'h0200, 16, -1, got);
      check("rd5_resp", got, {4{16'h00A7}});

      // CONVERT ch 7 as frame 0
      do_reset();
      frame("cv7", 16'h0700, 16, -1, got);
      frame("cv7_d1", 16'hE800, 16, -1, got);
      frame("cv7_d2", 16'hE800, 16, -1, got);
      check("cv7_resp", got, {16'h0700, 16'h4700, 16'h8700, 16'hC700});

      // Short frame then READ 63
      do_reset();
      frame("short10", 16'hFF00, 10, -1, got);
      check("short10_bfc", 64'(bad_frame_count), 64'd1);
      frame("rd63", 16'hFF00, 16, -1, got);
      frame("rd63_d1", 16'hE800, 16, -1, got);
      frame("rd63_d2", 16'hE800, 16, -1, got);
      check("rd63_resp", got, {4{16'h0001}});

      // WRITE to non-writable reg 20
      frame("wr20", 16'h9455, 16, -1, got);
      frame("rd20", 16'hD400, 16, -1, got);
      frame("wr20_d1", 16'hE800, 16, -1, got);
      check("wr20_resp", got, {4{16'hFF55}});
      frame("wr20_d2", 16'hE800, 16, -1, got);
      check("rd20_resp", got, 64'h0);

      // Zero-rise and 17-rise frames are bad
      frame("zero_rise", 16'hE800, 0, -1, got);
      frame("rise17", 16'hE800, 17, -1, got);

      // Enable dropped mid-frame
      frame("abort", 16'h85FF, 16, 5, got);
      frame("post_abort", 16'hC500, 16, -1, got);

      // Reset asserted in the middle of a frame
      csn = 1'b0; copi = 1'b1;
      #(HALF);
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b1; #(HALF);
         sclk = 1'b0; #(HALF);
      end
      rst = 1'b1;
      #1;
      check("midrst_cipo", {62'h0, cipo1, cipo0}, 64'h0);
      check("midrst_fc",   64'(frame_count), 64'h0);
      check("midrst_bfc",  64'(bad_frame_count), 64'h0);
      check("midrst_last", 64'(last_command), 64'h0);
      #(HALF-1);
      csn = 1'b1;
      #(HALF);
      rst = 1'b0;
      model_reset();
      #(2*HALF);
      frame("after_rst", 16'h8A3C, 16, -1, got);

      // Randomized command mix
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0: cmd = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
            1: case ($urandom_range(0, 2))
                  0: cmd = 16'h5500;
                  1: cmd = 16'h6A00;
                  default: cmd = {2'b01, 14'($urandom)};
               endcase
            2, 3: cmd = {2'b10, 6'($urandom_range(0, 23)), 8'($urandom)};
            default: cmd = {2'b11, 6'($urandom_range(0, 63)), 8'($urandom)};
         endcase
         rises = ($urandom_range(0, 7) == 0) ? 15 : 16;
         frame($sformatf("rnd%0d", n), cmd, rises, -1, got);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/intan_peripheral_emulator.md
Name: intan_peripheral_emulator

Overview:
- SPI peripheral model of a dual-line Intan-style amplifier.
- Decodes the 16-bit commands the acquisition controller drives on csn/sclk/copi and returns 16-bit responses on cipo0/cipo1, with two words per line per frame (A and B).
- Responses follow the chip's two-frame pipeline.
- Used in PL hardware-in-loop builds and benches so the acquisition path runs without a physical headstage.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on csn/sclk/copi (allowed range 2-3).
- PIPE_DEPTH, 2, frames between a command and its response.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when 0, cipo outputs are held 0 and frames are ignored
- csn  in  1  chip select, active low, asynchronous to clk
- sclk  in  1  serial clock, idle low
- copi  in  1  command data, MSB first, sampled on sclk rise
- cipo0  out  1  response line 0: bit of word A valid at sclk rise, bit of word B valid at sclk fall
- cipo1  out  1  response line 1, same format as cipo0
- frame_count  out  32  count of complete frames
- bad_frame_count  out  16  count of frames with a rise count other than 16; saturates at 0xFFFF
- last_command  out  16  most recent complete command

Behaviour:
- Reset (async, rst=1): cipo0=cipo1=0, all counters 0, last_command=0x0000, pipeline filled with 0x0000 responses, writable regs 0x00.
- Input conditioning:
  - csn, sclk and copi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies.
  - cipo outputs update 1 clk after the detected edge.
- States:
  - IDLE: csn fall -> SHIFT. Load the A/B shift registers from pipeline head; drive cipoN = A_N[15].
  - SHIFT:
    - sclk rise: shift copi into cmd_sr, increment rise_cnt, drive cipoN = B_N[bit].
    - sclk fall: advance bit, drive cipoN = A_N[next]; after the 16th fall, drive 0.
    - Rises beyond 16 are ignored; cipo stays 0.
    - csn rise -> DONE.
  - DONE, 1 clk:
    - rise_cnt==16: decode cmd_sr, push its response, pop the head, increment frame_count, set last_command.
    - Otherwise: no decode, pipeline unchanged, increment bad_frame_count.
    - Then -> IDLE.
- Decode (cmd[15:14]):
  - 00 CONVERT ch=cmd[13:8]: word = {line, sub, ch[5:0], frame_count[7:0]}, where line=0/1 and sub=0 for A, 1 for B.
  - 01 with cmd==0x5500 CALIBRATE, or cmd==0x6A00 CLEAR: response 0x0000. Any other 01 command is treated as CLEAR.
  - 10 WRITE reg=cmd[13:8], data=cmd[7:0]: reg<=data only when reg<=17. Response 0xFF00|data.
  - 11 READ reg: response {8'h00, value}. Values:
    - 0-17: writable regs
    - 40-44: 0x49, 0x4E, 0x54, 0x41, 0x4E ("INTAN")
    - 60: 0x01; 61: 0x00; 62: 0x20; 63: 0x01
    - anything else: 0x00
  - Non-CONVERT responses are identical on all four words.
- Latency: the response to command k appears in frame k+PIPE_DEPTH.
- A WRITE then READ of the same reg in consecutive frames returns the new value, because the write commits in DONE before the next decode.
- csn rising while rise_cnt==0 counts as a bad frame.
- enable deasserted mid-frame aborts the frame: -> IDLE, no counts change, cipo=0.
- Reset mid-frame clears everything immediately.
- frame_count wraps at 2^32.

Decomposition:
- Package intan_emu_pkg:
  - opcode enum (CONVERT, SPECIAL, WRITE, READ)
  - CALIBRATE_CMD 0x5500, CLEAR_CMD 0x6A00
  - ROM constant table, WRITABLE_MAX=17
  - response_t struct holding 4x16-bit words
- Sub-module sync_edge_detect: SYNC_STAGES synchronizer with rise/fall pulses, instantiated 3 times.

Test Plan:
- Reset, then send three READ 40 frames (0xE800) -> frames 1-2 return 0x0000 on all words; frame 3 returns 0x0049 on cipo0 A/B and cipo1 A/B; frame_count=3.
- WRITE reg 5 = 0xA7 (0x85A7), READ 5 (0xC500), two CONVERT dummies -> frame 3 returns 0xFFA7, frame 4 returns 0x00A7.
- CONVERT ch 7 (0x0700) as frame 0 (frame_count=0 at decode) -> two frames later, cipo0 A=0x0700, cipo0 B=0x4700, cipo1 A=0x8700, cipo1 B=0xC700.
- Frame with only 10 sclk pulses, then a valid READ 63 -> bad_frame_count=1, frame_count unchanged by the short frame, pipeline not advanced; the READ 63 response 0x0001 arrives 2 good frames later.
- WRITE reg 20 = 0x55, then READ 20 -> READ response 0x0000 (write ignored).
- Assert rst at bit 8 of a frame -> cipo=0 within the same cycle, counters 0; the next full frame decodes normally.
